// File: rtl/hdlc_rx_deframer.sv
// HDLC Rx deframer: flag hunt, zero deletion, abort, byte assembly, size/overflow.
// Define HDLC_RX_FCS_EN to add the CRC-16/X.25 FCS check.
module hdlc_rx_deframer #(
  parameter int MAX_BYTES = 126,
  parameter int MIN_BYTES = 4,
  parameter int SIZE_W    = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RxEN,
  input  logic              Rx,
  input  logic              Rx_Drop,
  output logic [7:0]        Rx_Data,
  output logic              Rx_DataValid,
  output logic              Rx_FlagDetect,
  output logic              Rx_AbortDetect,
  output logic              Rx_ValidFrame,
  output logic              Rx_EoF,
  output logic              Rx_FrameError,
  output logic [SIZE_W-1:0] Rx_FrameSize,
  output logic              Rx_Overflow
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    OPEN  = 2'd1,
    FRAME = 2'd2
  } state_t;

  localparam logic [SIZE_W-1:0] MAX_C = SIZE_W'(MAX_BYTES);
  localparam logic [SIZE_W-1:0] SAT_C = SIZE_W'(MAX_BYTES + 1);
  localparam logic [SIZE_W-1:0] MIN_C = SIZE_W'(MIN_BYTES);
  localparam logic [SIZE_W-1:0] ONE_C = SIZE_W'(1);

  state_t            state, state_nxt;
  logic [7:0]        win, win_nxt;
  logic [7:0]        sh, sh_nxt;
  logic [3:0]        skip;
  logic [2:0]        ones;
  logic [2:0]        bits, bits_after;
  logic [SIZE_W-1:0] cnt, cnt_after, size_val;

  logic drop, strobe, exit_b;
  logic is_flag, is_abort;
  logic live, keep, done;
  logic emit, ovf_hit, in_frame, ovf_after;
  logic fcs_bad, eof_d, err_d;

  // Drop beats a same-cycle strobe; the flag's own 8 bits are
  // flushed through the window (skip) before data assembly resumes.
  assign drop       = Rx_Drop && (state != HUNT);
  assign strobe     = RxEN && !drop;
  assign win_nxt    = {Rx, win[7:1]};
  assign exit_b     = win[0];
  assign is_flag    = strobe && (win_nxt == 8'h7E);
  assign is_abort   = strobe && (&win_nxt[7:1]);
  assign live       = strobe && (state != HUNT) && !is_abort
                      && (skip == 4'd0);
  assign keep       = live && !(!exit_b && (ones == 3'd5));
  assign done       = keep && (bits == 3'd7);
  assign sh_nxt     = {exit_b, sh[7:1]};
  assign bits_after = keep ? bits + 3'd1 : bits;
  assign emit       = done && (cnt < MAX_C);
  assign ovf_hit    = done && (cnt >= MAX_C);
  assign cnt_after  = emit ? cnt + ONE_C : (ovf_hit ? SAT_C : cnt);
  assign in_frame   = (state == FRAME) || ((state == OPEN) && done);
  assign ovf_after  = ((state == OPEN) && done) ? 1'b0
                      : (Rx_Overflow || ovf_hit);

`ifdef HDLC_RX_FCS_EN
  logic [15:0] crc, crc_nxt;

  assign crc_nxt  = !keep ? crc
                    : ({1'b0, crc[15:1]}
                       ^ ((crc[0] ^ exit_b) ? 16'h8408 : 16'h0000));
  assign fcs_bad  = (crc_nxt != 16'hF0B8);
  assign size_val = (cnt_after < SIZE_W'(2)) ? '0
                    : cnt_after - SIZE_W'(2);

  // CRC restarts on every flag, runs over each kept bit
  always_ff @(posedge Clk) begin
    if (Rst)
      crc <= 16'h0000;
    else if (is_flag || is_abort)
      crc <= 16'hFFFF;
    else if (strobe)
      crc <= crc_nxt;
  end
`else
  assign fcs_bad  = 1'b0;
  assign size_val = cnt_after;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Rst)
      state <= HUNT;
    else
      state <= state_nxt;
  end

  // Next state: drop, then abort, then flag, then first byte
  always_comb begin
    state_nxt = state;
    if (drop)
      state_nxt = HUNT;
    else if (is_abort)
      state_nxt = HUNT;
    else if (is_flag)
      state_nxt = OPEN;
    else if ((state == OPEN) && done)
      state_nxt = FRAME;
  end

  // End-of-frame decode and error status
  always_comb begin
    eof_d = 1'b0;
    err_d = 1'b0;
    if (is_abort) begin
      eof_d = (state == FRAME);
      err_d = 1'b1;
    end else if (is_flag && in_frame) begin
      eof_d = 1'b1;
      err_d = (bits_after != 3'd0) || (cnt_after < MIN_C)
              || ovf_after || fcs_bad;
    end
  end

  // Window, destuffing and byte assembly datapath
  always_ff @(posedge Clk) begin
    if (Rst) begin
      win  <= '0;
      skip <= '0;
      ones <= '0;
      sh   <= '0;
      bits <= '0;
      cnt  <= '0;
    end else if (strobe) begin
      win <= win_nxt;
      if (is_flag || is_abort) begin
        skip <= is_flag ? 4'd8 : 4'd0;
        ones <= '0;
        sh   <= '0;
        bits <= '0;
        cnt  <= '0;
      end else begin
        if (skip != 4'd0)
          skip <= skip - 4'd1;
        if (live)
          ones <= !exit_b ? 3'd0
                  : ((ones == 3'd7) ? ones : ones + 3'd1);
        if (keep) begin
          sh   <= sh_nxt;
          bits <= bits_after;
        end
        cnt <= cnt_after;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Rx_Data        <= '0;
      Rx_DataValid   <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_FrameSize   <= '0;
      Rx_Overflow    <= 1'b0;
    end else begin
      Rx_DataValid   <= emit;
      Rx_FlagDetect  <= is_flag;
      Rx_AbortDetect <= is_abort;
      Rx_EoF         <= eof_d;
      Rx_ValidFrame  <= (state_nxt != HUNT);
      Rx_Overflow    <= ovf_after;
      if (emit)
        Rx_Data <= sh_nxt;
      if (eof_d) begin
        Rx_FrameError <= err_d;
        Rx_FrameSize  <= size_val;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: default instance plus a MAX_BYTES=4
// instance sharing the same line stream.
module tb_hdlc_rx_deframer;

`ifdef HDLC_RX_FCS_EN
  localparam bit FCS = 1'b1;
`else
  localparam bit FCS = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst, RxEN, Rx, Rx_Drop;
  logic [7:0] d_data, o_data;
  logic       d_dv, d_flag, d_abort, d_valid, d_eof, d_err, d_ovf;
  logic       o_dv, o_flag, o_abort, o_valid, o_eof, o_err, o_ovf;
  logic [7:0] d_size, o_size;

  always #5 Clk = ~Clk;

  hdlc_rx_deframer u_dut (
    .Clk(Clk), .Rst(Rst), .RxEN(RxEN), .Rx(Rx), .Rx_Drop(Rx_Drop),
    .Rx_Data(d_data), .Rx_DataValid(d_dv), .Rx_FlagDetect(d_flag),
    .Rx_AbortDetect(d_abort), .Rx_ValidFrame(d_valid), .Rx_EoF(d_eof),
    .Rx_FrameError(d_err), .Rx_FrameSize(d_size), .Rx_Overflow(d_ovf)
  );

  hdlc_rx_deframer #(.MAX_BYTES(4)) u_ovf (
    .Clk(Clk), .Rst(Rst), .RxEN(RxEN), .Rx(Rx), .Rx_Drop(Rx_Drop),
    .Rx_Data(o_data), .Rx_DataValid(o_dv), .Rx_FlagDetect(o_flag),
    .Rx_AbortDetect(o_abort), .Rx_ValidFrame(o_valid), .Rx_EoF(o_eof),
    .Rx_FrameError(o_err), .Rx_FrameSize(o_size), .Rx_Overflow(o_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int dv_total = 0, eof_total = 0, ab_total = 0, fl_total = 0;
  int odv_total = 0, oeof_total = 0;
  int dv0, eof0, ab0, fl0, odv0, oeof0;
  int ones_run = 0;
  bit sparse = 1'b0;
  logic [7:0] byte_log [256];
  logic [7:0] frm [11];

  // Pulse monitor, sampled mid-cycle
  always @(negedge Clk) begin
    if (d_dv) begin
      byte_log[dv_total % 256] = d_data;
      dv_total++;
    end
    if (d_eof)   eof_total++;
    if (d_abort) ab_total++;
    if (d_flag)  fl_total++;
    if (o_dv)    odv_total++;
    if (o_eof)   oeof_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    RxEN = 1'b1;
    @(posedge Clk);
    #1;
    RxEN = 1'b0;
    if (sparse) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic raw(input logic b);
    send_bit(b);
    ones_run = b ? ones_run + 1 : 0;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    ones_run = 0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      raw(v[i]);
      if (ones_run == 5) raw(1'b0);
    end
  endtask

  task automatic settle();
    RxEN = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic snap();
    dv0 = dv_total; eof0 = eof_total; ab0 = ab_total;
    fl0 = fl_total; odv0 = odv_total; oeof0 = oeof_total;
  endtask

  initial begin
    Rst = 1'b1; RxEN = 1'b0; Rx = 1'b0; Rx_Drop = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check("rst_valid", 32'(d_valid), 0);
    check("rst_err", 32'(d_err), 0);
    check("rst_size", 32'(d_size), 0);
    check("rst_ovf", 32'(d_ovf), 0);
    check("rst_data", 32'(d_data), 0);

    // Good frame: "123456789" + FCS 0x906E
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
            8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    snap();
    send_flag();
    for (int i = 0; i < 11; i++) send_byte(frm[i]);
    send_flag();
    settle();
    check("good_dv", 32'(dv_total - dv0), 11);
    for (int i = 0; i < 11; i++)
      check("good_byte", 32'(byte_log[(dv0 + i) % 256]), 32'(frm[i]));
    check("good_eof", 32'(eof_total - eof0), 1);
    check("good_flags", 32'(fl_total - fl0), 2);
    check("good_err", 32'(d_err), 0);
    check("good_size", 32'(d_size), FCS ? 9 : 11);
    check("good_valid", 32'(d_valid), 1);

    // Back-to-back flags: idle fill, no EoF
    snap();
    send_flag();
    send_flag();
    settle();
    check("b2b_eof", 32'(eof_total - eof0), 0);
    check("b2b_flags", 32'(fl_total - fl0), 2);
    check("b2b_valid", 32'(d_valid), 1);

    // Bad FCS, sparse strobes
    frm[10] = 8'h91;
    sparse = 1'b1;
    snap();
    for (int i = 0; i < 11; i++) send_byte(frm[i]);
    send_flag();
    sparse = 1'b0;
    settle();
    check("badfcs_dv", 32'(dv_total - dv0), 11);
    check("badfcs_last", 32'(byte_log[(dv0 + 10) % 256]), 8'h91);
    check("badfcs_eof", 32'(eof_total - eof0), 1);
    check("badfcs_err", 32'(d_err), FCS ? 1 : 0);
    check("badfcs_size", 32'(d_size), FCS ? 9 : 11);

    // Zero deletion: FF stuffed in-byte, then a stuffed 0
    // spanning the FF/03 boundary
    snap();
    raw(1); raw(1); raw(1); raw(1); raw(1); raw(0);
    raw(1); raw(1); raw(1);
    raw(1); raw(1); raw(0);
    raw(0); raw(0); raw(0); raw(0); raw(0); raw(0);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_flag();
    settle();
    check("zd_dv", 32'(dv_total - dv0), 4);
    check("zd_b0", 32'(byte_log[dv0 % 256]), 8'hFF);
    check("zd_b1", 32'(byte_log[(dv0 + 1) % 256]), 8'h03);
    check("zd_b2", 32'(byte_log[(dv0 + 2) % 256]), 8'h55);
    check("zd_b3", 32'(byte_log[(dv0 + 3) % 256]), 8'hAA);
    check("zd_size", 32'(d_size), FCS ? 2 : 4);

    // Abort: 8 ones mid-frame
    snap();
    send_byte(8'h12);
    send_byte(8'h34);
    for (int i = 0; i < 8; i++) raw(1'b1);
    settle();
    check("abort_pulses", 32'(ab_total - ab0), 2);
    check("abort_eof", 32'(eof_total - eof0), 1);
    check("abort_err", 32'(d_err), 1);
    check("abort_dv", 32'(dv_total - dv0), 1);
    check("abort_size", 32'(d_size), FCS ? 0 : 1);
    check("abort_valid", 32'(d_valid), 0);
    snap();
    send_flag();
    settle();
    check("reopen_valid", 32'(d_valid), 1);
    check("reopen_eof", 32'(eof_total - eof0), 0);

    // Three stray bits before the closing flag
    snap();
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h44); send_byte(8'h88);
    raw(0); raw(1); raw(0);
    send_flag();
    settle();
    check("stray_dv", 32'(dv_total - dv0), 4);
    check("stray_err", 32'(d_err), 1);
    check("stray_size", 32'(d_size), FCS ? 2 : 4);

    // Overflow on the MAX_BYTES=4 instance: 6 bytes
    snap();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    send_flag();
    settle();
    check("ovf_dv", 32'(odv_total - odv0), 4);
    check("ovf_flag", 32'(o_ovf), 1);
    check("ovf_eof", 32'(oeof_total - oeof0), 1);
    check("ovf_err", 32'(o_err), 1);
    check("ovf_size", 32'(o_size), FCS ? 3 : 5);
    check("big_dv", 32'(dv_total - dv0), 6);
    check("big_ovf", 32'(d_ovf), 0);
    check("big_size", 32'(d_size), FCS ? 4 : 6);

    // Next frame entering FRAME clears overflow; then drop
    snap();
    send_byte(8'h5A);
    send_byte(8'h5A);
    settle();
    check("ovf_clear", 32'(o_ovf), 0);
    Rx_Drop = 1'b1;
    Rx = 1'b0;
    RxEN = 1'b1;
    @(posedge Clk);
    #1;
    Rx_Drop = 1'b0;
    RxEN = 1'b0;
    settle();
    check("drop_valid", 32'(d_valid), 0);
    send_byte(8'h5A);
    send_flag();
    settle();
    check("drop_eof", 32'(eof_total - eof0), 0);
    check("drop_oeof", 32'(oeof_total - oeof0), 0);
    check("drop_size", 32'(d_size), FCS ? 4 : 6);
    check("drop_osize", 32'(o_size), FCS ? 3 : 5);
    check("drop_oerr", 32'(o_err), 1);
    check("drop_reopen", 32'(d_valid), 1);

    // Reset mid-frame
    snap();
    send_byte(8'h77);
    send_byte(8'h33);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    settle();
    check("mrst_eof", 32'(eof_total - eof0), 0);
    check("mrst_valid", 32'(d_valid), 0);
    check("mrst_size", 32'(d_size), 0);
    check("mrst_err", 32'(d_err), 0);
    check("mrst_data", 32'(d_data), 0);
    check("mrst_oerr", 32'(o_err), 0);
    check("mrst_pulses", 32'({d_dv, d_eof, d_flag, d_abort}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
